eth_csr_sequencer: RTL and testbench
====================================

# eth_csr_sequencer

Clock-domain-`clk` controller that serializes Ethernet MAC/PHY CSR accesses from several requesters (host MMIO path, init engine, stats poller) onto the single `ctrl_addr`/`wr_data`/`rd_data` register triple. That triple crosses into the HSSI management clock through two-stage synchronizers. The management side edge-detects the command strobes `ctrl_addr[16]` (write) and `ctrl_addr[17]` (read). The sequencer grants one requester at a time with round-robin arbitration. For each command it holds the strobe, clears it, and waits long enough for the crossing to settle, then returns a response.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (≥1).
- `HOLD_CYCLES`, 16: `clk` cycles each strobe phase (asserted, then cleared) is held (≥1). Must cover sync depth plus the clock ratio.
- `RD_WAIT`, 16: `clk` cycles after strobe clear before `rd_data` is sampled (≥1).

Ports:
- `clk`  in  1  clock.
- `pck_cp2af_softReset_T1`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*16  CSR address, requester i at [16i+15:16i].
- `req_wdata`  in  NUM_REQ*32  write data, requester i at [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse to the originating requester.
- `rsp_rdata`  out  32  read data, valid with `rsp_valid` of a read.
- `ctrl_addr`  out  32  `[15:0]` address, `[16]` write strobe, `[17]` read strobe, `[31:18]` zero.
- `wr_data`  out  32  write data to the crossing.
- `rd_data`  in  32  synchronized read data from the crossing.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, CLEAR, WAIT_RD, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Pulse `req_ready[g]` and capture `g`, write, addr and wdata.
  - Go to ISSUE.
- ISSUE:
  - `ctrl_addr = {14'b0, rd, wr, addr}` and `wr_data = wdata`.
  - Exactly one strobe is high.
  - Stay for HOLD_CYCLES, then go to CLEAR.
- CLEAR:
  - Strobes go low; address and `wr_data` stay held.
  - Stay for HOLD_CYCLES.
  - Then go to WAIT_RD for a read, or RESP for a write.
- WAIT_RD:
  - Stay for RD_WAIT cycles.
  - On the last cycle, register `rd_data` into `rsp_rdata`.
- RESP:
  - Pulse `rsp_valid[g]`.
  - Set `rr_ptr = (g+1) mod NUM_REQ`.
  - Return to IDLE.
- `rsp_rdata` holds its value until the next read completes. It is unchanged by writes.
- A requester keeps `req_valid` and its fields stable until `req_ready`. Dropping `req_valid` before a grant simply withdraws the request.
- Only one command is in flight at a time. Requests arriving while busy wait.
- Simultaneous valids are resolved by `rr_ptr` only. With all requesters continuously valid, the grant sequence is 0,1,…,NUM_REQ-1,0,…
- Reset is asynchronous. All outputs, `rr_ptr` and the counters go to 0, and the state goes to IDLE.
- Reset mid-operation drops the strobes immediately and issues no response. The aborted request must be re-presented.
- Counters are `$clog2(max(HOLD_CYCLES,RD_WAIT))+1` bits wide. They load 0 on each state entry and compare against the parameter minus 1.

## Timing
- Accept occurs in cycle T (`req_ready` high); IDLE→ISSUE takes one cycle.
- The strobe is visible on `ctrl_addr` in cycles T+1 … T+HOLD_CYCLES.
- The strobe is low from cycle T+HOLD_CYCLES+1.
- Write latency: `rsp_valid` in cycle T+1+2·HOLD_CYCLES.
- Read latency: `rsp_valid` in cycle T+1+2·HOLD_CYCLES+RD_WAIT.
  - `rsp_rdata` is valid in the same cycle.
  - `rd_data` is sampled in the preceding cycle.
- The earliest next accept is the cycle after RESP, so there is a one-cycle IDLE gap.
- `req_ready` never asserts while `busy` is high.
- `ctrl_addr` and `wr_data` are driven directly from flops with no combinational path from inputs. All outputs are registered.

## Structure
- Shared package `eth_csr_pkg` holds:
  - `ETH_CMD_WR_BIT=16` and `ETH_CMD_RD_BIT=17`;
  - the address width of 16 and data width of 32;
  - the typedef `t_eth_csr_state` enum.
- Sub-module `eth_csr_rr_arb` contains the parameterized round-robin grant logic.
  - Combinational; takes the `req_valid` vector and `rr_ptr`.
  - Outputs a one-hot grant and its index.
  - Reused by the stats poller.

## Test plan
- **Single write:** requester 0, addr 0x0010, wdata 0xDEADBEEF, HOLD=4.
  - `ctrl_addr=0x0001_0010` for cycles T+1..T+4, then 0x0000_0010.
  - `wr_data=0xDEADBEEF`; `rsp_valid[0]` at T+9.
- **Single read:** requester 1, addr 0x0020, bench drives `rd_data=0x12345678`, HOLD=4, RD_WAIT=3.
  - `ctrl_addr[17]` high for 4 cycles.
  - `rsp_valid[1]` at T+12 with `rsp_rdata=0x12345678`.
- **Contention:** both requesters valid continuously with 3 requests each.
  - Grants alternate 0,1,0,1,0,1.
  - Every `rsp_valid` matches its grant index.
- **Busy back-pressure:** a new `req_valid` arrives during ISSUE.
  - No `req_ready` until the cycle after RESP.
  - Exactly one strobe is active at any time.
- **Reset mid-ISSUE:** assert reset during the read strobe.
  - `ctrl_addr` becomes 0 in the same cycle; no `rsp_valid`; `rr_ptr` is 0.
  - After reset a new request is accepted normally.
- **Withdrawn request:** `req_valid[1]` pulses for one cycle while busy with requester 0.
  - No grant to requester 1; state returns to IDLE; `busy` goes low.

Source files
------------

// File: rtl/eth_csr_pkg.sv
// rtl/eth_csr_pkg.sv - shared constants and state type for the Ethernet CSR sequencer
package eth_csr_pkg;

  localparam int ETH_CMD_WR_BIT = 16;
  localparam int ETH_CMD_RD_BIT = 17;
  localparam int ETH_CSR_AW     = 16;
  localparam int ETH_CSR_DW     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CLEAR,
    ST_WAIT_RD,
    ST_RESP
  } t_eth_csr_state;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_csr_sequencer_if.sv
// rtl/eth_csr_sequencer_if.sv - requester and CSR-crossing signal bundle
interface eth_csr_sequencer_if #(
  parameter int NUM_REQ = 2
);
  import eth_csr_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ETH_CSR_AW-1:0] req_addr;
  logic [NUM_REQ*ETH_CSR_DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [ETH_CSR_DW-1:0]         rsp_rdata;
  logic [31:0]                   ctrl_addr;
  logic [ETH_CSR_DW-1:0]         wr_data;
  logic [ETH_CSR_DW-1:0]         rd_data;
  logic                          busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rd_data,
    output req_ready, rsp_valid, rsp_rdata, ctrl_addr, wr_data, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rd_data,
    input  req_ready, rsp_valid, rsp_rdata, ctrl_addr, wr_data, busy
  );

endinterface

// File: rtl/eth_csr_rr_arb.sv
// rtl/eth_csr_rr_arb.sv - combinational round-robin grant: first valid at or after ptr
module eth_csr_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!any && valid[pos[IDX_W-1:0]]) begin
        any                   = 1'b1;
        grant[pos[IDX_W-1:0]] = 1'b1;
        idx                   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/eth_csr_sequencer.sv
// rtl/eth_csr_sequencer.sv - serializes requester CSR accesses onto the strobed
// ctrl_addr/wr_data/rd_data triple that crosses into the HSSI management clock.
module eth_csr_sequencer
  import eth_csr_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int RD_WAIT     = 16
) (
  input logic                clk,
  input logic                pck_cp2af_softReset_T1,
  eth_csr_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, RD_WAIT)) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT - 1);

  t_eth_csr_state        state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      g_idx;
  logic [IDX_W-1:0]      rr_next;
  logic [NUM_REQ-1:0]    g_onehot;
  logic                  cur_write;
  logic [ETH_CSR_AW-1:0] cur_addr;
  logic [ETH_CSR_DW-1:0] cur_wdata;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  arbitrate;
  logic [ETH_CSR_AW-1:0] addr_arr  [NUM_REQ];
  logic [ETH_CSR_DW-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr[i*ETH_CSR_AW +: ETH_CSR_AW];
    assign wdata_arr[i] = bus.req_wdata[i*ETH_CSR_DW +: ETH_CSR_DW];
  end

  eth_csr_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Arbitrating during RESP lets the registered accept land in the IDLE cycle right after it.
  assign arbitrate = ((state == ST_IDLE) && (bus.req_ready == '0)) || (state == ST_RESP);
  assign rr_next   = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
  assign g_onehot  = NUM_REQ'(1) << g_idx;

  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      g_idx         <= '0;
      cur_write     <= 1'b0;
      cur_addr      <= '0;
      cur_wdata     <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.ctrl_addr <= '0;
      bus.wr_data   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      if (arbitrate && arb_any) begin
        bus.req_ready <= arb_grant;
        g_idx         <= arb_idx;
        cur_write     <= bus.req_write[arb_idx];
        cur_addr      <= addr_arr[arb_idx];
        cur_wdata     <= wdata_arr[arb_idx];
      end
      case (state)
        ST_IDLE: begin
          if (bus.req_ready != '0) begin
            state         <= ST_ISSUE;
            cnt           <= '0;
            bus.busy      <= 1'b1;
            bus.ctrl_addr <= {14'b0, ~cur_write, cur_write, cur_addr};
            bus.wr_data   <= cur_wdata;
          end
        end
        ST_ISSUE: begin
          if (cnt == HOLD_LAST) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            bus.ctrl_addr[ETH_CMD_RD_BIT:ETH_CMD_WR_BIT] <= 2'b00;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (cur_write) begin
              state         <= ST_RESP;
              bus.rsp_valid <= g_onehot;
              rr_ptr        <= rr_next;
            end else begin
              state <= ST_WAIT_RD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_RD: begin
          if (cnt == RD_LAST) begin
            state         <= ST_RESP;
            cnt           <= '0;
            bus.rsp_rdata <= bus.rd_data;
            bus.rsp_valid <= g_onehot;
            rr_ptr        <= rr_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_csr_sequencer.sv
// tb/tb_eth_csr_sequencer.sv - directed bench with a cycle-offset reference model
module tb_eth_csr_sequencer;

  localparam int N      = 2;
  localparam int H      = 4;
  localparam int RW     = 3;
  localparam int LAT_WR = 1 + 2*H;
  localparam int LAT_RD = 1 + 2*H + RW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  eth_csr_sequencer_if #(.NUM_REQ(N)) bus_if ();

  eth_csr_sequencer #(
    .NUM_REQ     (N),
    .HOLD_CYCLES (H),
    .RD_WAIT     (RW)
  ) dut (
    .clk                    (clk),
    .pck_cp2af_softReset_T1 (rst),
    .bus                    (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each transaction is described by its accept cycle; outputs follow from the offset.
  logic        m_pend = 1'b0, m_act = 1'b0, m_w = 1'b0, m_pw = 1'b0;
  int          m_acc = 0, m_g = 0, m_pg = 0, m_rr = 0, d, lat, mi;
  logic [15:0] m_addr = '0, m_paddr = '0;
  logic [31:0] m_wd = '0, m_pwd = '0;
  logic [31:0] ctrl_hold = '0, wd_hold = '0, rdata_hold = '0, rd_sample = '0, exp_ctrl;
  logic [N-1:0] exp_ready, exp_rsp;
  logic        exp_busy;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", 32'(bus_if.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
      check("rst_ctrl_addr", bus_if.ctrl_addr, 32'h0);
      check("rst_busy", 32'(bus_if.busy), 32'h0);
      m_pend = 1'b0; m_act = 1'b0; m_rr = 0;
      ctrl_hold = '0; wd_hold = '0; rdata_hold = '0;
    end else begin
      if (m_pend) begin
        m_act = 1'b1; m_acc = cyc; m_g = m_pg; m_w = m_pw;
        m_addr = m_paddr; m_wd = m_pwd; m_pend = 1'b0;
      end
      d   = m_act ? cyc - m_acc : -1;
      lat = m_w ? LAT_WR : LAT_RD;
      exp_ready = (m_act && d == 0) ? N'(1 << m_g) : '0;
      if (m_act && d >= 1) begin
        ctrl_hold = {16'h0, m_addr};
        wd_hold   = m_wd;
      end
      exp_ctrl = ctrl_hold;
      if (m_act && d >= 1 && d <= H) exp_ctrl[m_w ? 16 : 17] = 1'b1;
      if (m_act && !m_w && d == lat - 1) rd_sample = bus_if.rd_data;
      if (m_act && !m_w && d == lat) rdata_hold = rd_sample;
      exp_rsp  = (m_act && d == lat) ? N'(1 << m_g) : '0;
      exp_busy = m_act && d >= 1;
      check("req_ready", 32'(bus_if.req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(bus_if.rsp_valid), 32'(exp_rsp));
      check("ctrl_addr", bus_if.ctrl_addr, exp_ctrl);
      check("wr_data", bus_if.wr_data, wd_hold);
      check("rsp_rdata", bus_if.rsp_rdata, rdata_hold);
      check("busy", 32'(bus_if.busy), 32'(exp_busy));
      if (m_act && d == lat) begin
        m_rr  = (m_g + 1) % N;
        m_act = 1'b0;
      end
      if (!m_act) begin
        for (int k = 0; k < N; k++) begin
          mi = (m_rr + k) % N;
          if (!m_pend && bus_if.req_valid[mi]) begin
            m_pend  = 1'b1;
            m_pg    = mi;
            m_pw    = bus_if.req_write[mi];
            m_paddr = bus_if.req_addr[16*mi +: 16];
            m_pwd   = bus_if.req_wdata[32*mi +: 32];
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [15:0] a, input logic [31:0] wd);
    bus_if.req_valid[i]         = v;
    bus_if.req_write[i]         = w;
    bus_if.req_addr[16*i +: 16] = a;
    bus_if.req_wdata[32*i +: 32] = wd;
  endtask

  task automatic at(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic wait_any(output int t, output logic [N-1:0] g);
    t = -1; g = '0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus_if.req_ready != '0) begin
        t = cyc; g = bus_if.req_ready;
        break;
      end
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL accept_timeout: got no req_ready expected one within 64 cycles");
    end
  endtask

  task automatic wait_ready(input int i, output int t);
    t = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus_if.req_ready[i]) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL ready_timeout: got no req_ready[%0d] expected one within 64 cycles", i);
    end
  endtask

  int           t, t2, n;
  logic [N-1:0] g;
  int           cnt [N];
  int           order [$];

  initial begin
    bus_if.req_valid = '0; bus_if.req_write = '0;
    bus_if.req_addr  = '0; bus_if.req_wdata = '0;
    bus_if.rd_data   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single write
    @(posedge clk); #1 set_req(0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    wait_ready(0, t);
    @(posedge clk); #1 bus_if.req_valid[0] = 1'b0;
    if (t >= 0) begin
      at(t + 1);  check("wr_strobe_first", bus_if.ctrl_addr, 32'h0001_0010);
                  check("wr_data_lit", bus_if.wr_data, 32'hDEADBEEF);
      at(t + 4);  check("wr_strobe_last", bus_if.ctrl_addr, 32'h0001_0010);
      at(t + 5);  check("wr_strobe_clear", bus_if.ctrl_addr, 32'h0000_0010);
      at(t + 8);  check("wr_rsp_early", 32'(bus_if.rsp_valid), 32'h0);
      at(t + 9);  check("wr_rsp_lit", 32'(bus_if.rsp_valid), 32'h1);
      at(t + 10); check("wr_busy_low", 32'(bus_if.busy), 32'h0);
    end

    // single read
    @(posedge clk); #1 bus_if.rd_data = 32'h12345678;
    set_req(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    wait_ready(1, t);
    @(posedge clk); #1 bus_if.req_valid[1] = 1'b0;
    if (t >= 0) begin
      at(t + 1);  check("rd_strobe_first", bus_if.ctrl_addr, 32'h0002_0020);
      at(t + 4);  check("rd_strobe_last", bus_if.ctrl_addr, 32'h0002_0020);
      at(t + 5);  check("rd_strobe_clear", bus_if.ctrl_addr, 32'h0000_0020);
      at(t + 11); check("rd_rsp_early", 32'(bus_if.rsp_valid), 32'h0);
      at(t + 12); check("rd_rsp_lit", 32'(bus_if.rsp_valid), 32'h2);
                  check("rd_data_lit", bus_if.rsp_rdata, 32'h12345678);
    end

    // contention: both requesters continuously valid, three requests each
    @(posedge clk); #1;
    cnt[0] = 0; cnt[1] = 0; n = 0;
    set_req(0, 1'b1, 1'b1, 16'h0100, 32'hA0A0_0000);
    set_req(1, 1'b1, 1'b0, 16'h0200, 32'hB0B0_0000);
    while ((cnt[0] < 3 || cnt[1] < 3 || bus_if.busy) && n < 400) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus_if.req_ready[i]) begin
          order.push_back(i);
          cnt[i]++;
        end
      end
      @(posedge clk); #1;
      bus_if.rd_data = $urandom;
      for (int i = 0; i < N; i++) begin
        set_req(i, cnt[i] < 3, 1'((cnt[i] + i) % 2), 16'(16'h0100 * (i + 1) + cnt[i]),
                32'hC000_0000 + 32'(i * 16 + cnt[i]));
      end
      n++;
    end
    check("contention_grants", 32'(order.size()), 32'd6);
    foreach (order[k]) check("contention_order", 32'(order[k]), 32'(k % 2));

    // busy back-pressure: requester 0 arrives during requester 1's ISSUE
    @(posedge clk); #1 set_req(1, 1'b1, 1'b1, 16'h0300, 32'h3333_3333);
    wait_ready(1, t);
    @(posedge clk); #1 bus_if.req_valid[1] = 1'b0;
    @(posedge clk); #1 set_req(0, 1'b1, 1'b0, 16'h0400, 32'h0);
    wait_ready(0, t2);
    check("backpressure_accept", 32'(t2 - t), 32'(LAT_WR + 1));
    @(posedge clk); #1 bus_if.req_valid[0] = 1'b0;
    if (t2 >= 0) at(t2 + LAT_RD);

    // reset during the read strobe; rr_ptr was 1 before the abort
    @(posedge clk); #1 set_req(1, 1'b1, 1'b0, 16'h0500, 32'h0);
    wait_ready(1, t);
    @(posedge clk); #1 bus_if.req_valid[1] = 1'b0;
    if (t >= 0) at(t + 2);
    #1 rst = 1'b1;
    #1 check("rst_async_ctrl", bus_if.ctrl_addr, 32'h0);
    check("rst_async_busy", 32'(bus_if.busy), 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0600, 32'h6666_6666);
    set_req(1, 1'b1, 1'b1, 16'h0700, 32'h7777_7777);
    wait_any(t, g);
    check("rst_rr_ptr", 32'(g), 32'h1);
    @(posedge clk); #1 bus_if.req_valid[0] = 1'b0;
    wait_ready(1, t);
    @(posedge clk); #1 bus_if.req_valid[1] = 1'b0;
    if (t >= 0) at(t + LAT_WR + 1);

    // withdrawn request from requester 1 while busy with requester 0
    @(posedge clk); #1 set_req(0, 1'b1, 1'b1, 16'h0800, 32'h8888_8888);
    wait_any(t, g);
    check("withdraw_grant", 32'(g), 32'h1);
    @(posedge clk); #1 bus_if.req_valid[0] = 1'b0;
    @(posedge clk); #1 set_req(1, 1'b1, 1'b0, 16'h0900, 32'h0);
    @(posedge clk); #1 bus_if.req_valid[1] = 1'b0;
    if (t >= 0) begin
      at(t + LAT_WR);     check("withdraw_rsp", 32'(bus_if.rsp_valid), 32'h1);
      at(t + LAT_WR + 1); check("withdraw_idle", 32'(bus_if.busy), 32'h0);
                          check("withdraw_no_grant", 32'(bus_if.req_ready), 32'h0);
      at(t + LAT_WR + 3); check("withdraw_still_idle", 32'(bus_if.busy), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
